// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the SNN phase scheduler block:
//   SNN_VEC_W   - width of one spike vector (one bit per input neuron)
//   snn_state_t - scheduler state encoding
//   snn_max     - elaboration-time max of two integers
//   snn_width   - bit width needed to hold values 0..n-1 (minimum 1)
// ---------------------------------------------------------------------------
package snn_pkg;

   localparam int SNN_VEC_W = 42;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GAP   = 3'd1,
      ST_FETCH = 3'd2,
      ST_EMIT  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DONE  = 3'd5
   } snn_state_t;

   function automatic int snn_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int snn_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snn_delay_counter.sv
// ---------------------------------------------------------------------------
// snn_delay_counter
// Down-counter shared by the GAP and HOLD phases. A load presets the count
// to (phase length - 1); the count then decrements once per cycle unless
// paused, and sticks at zero. Expire is the terminal-count compare, so a
// phase of length L lasts L cycles from the cycle after the load.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset (count cleared)
//   i_load      preset the count this cycle (has priority over pause)
//   i_load_val  preset value
//   i_pause     hold the current count
//   o_expire    count has reached zero
// ---------------------------------------------------------------------------
module snn_delay_counter #(
   parameter int P_W = 4
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_load,
   input  logic [P_W-1:0] i_load_val,
   input  logic           i_pause,
   output logic           o_expire
);

   logic [P_W-1:0] cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else if (i_load) begin
         cnt_q <= i_load_val;
      end else if (!i_pause && (cnt_q != '0)) begin
         cnt_q <= cnt_q - P_W'(1);
      end
   end

   assign o_expire = (cnt_q == '0);

endmodule

// File: rtl/snn_phase_scheduler.sv
// ---------------------------------------------------------------------------
// snn_phase_scheduler
// Sequences spike-vector presentation to the network: for every frame
// (pattern set) and every epoch within it, waits an idle gap, then reads each
// pattern-memory word in turn, emits it for one cycle and follows it with a
// run of zero vectors. STDP learning is enabled only during frame 0.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for i_start; last frame/epoch/addr still visible
//   GAP   | idle cycles before an epoch (pausable)
//   FETCH | o_rd_en high for the current address
//   EMIT  | memory data presented on o_spike_vec for one cycle
//   HOLD  | zero vectors after an emission (pausable), then advance
//   DONE  | one-cycle o_done pulse, then back to IDLE
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          run request (ignored unless IDLE)
//   i_pause          freezes GAP/HOLD timing
//   o_rd_en, o_addr  pattern-memory read strobe and address
//   o_frame          pattern-set select
//   i_rd_data        memory data, valid the cycle after o_rd_en
//   o_spike_vec      spike vector to the network (zero outside EMIT)
//   o_learn_en       STDP enable
//   o_epoch          current epoch, 1-based
//   o_busy, o_done   activity flag, end-of-run pulse
// ---------------------------------------------------------------------------
module snn_phase_scheduler
   import snn_pkg::*;
#(
   parameter int P_TEST_LEN     = 9000,
   parameter int P_PATTERN_GAP  = 100,
   parameter int P_SPIKE_GAP    = 3,
   parameter int P_EPOCHS_TRAIN = 100,
   parameter int P_EPOCHS_TEST  = 50,
   parameter int P_FRAMES       = 4
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_start,
   input  logic                                i_pause,
   output logic                                o_rd_en,
   output logic [snn_width(P_TEST_LEN)-1:0]    o_addr,
   output logic [1:0]                          o_frame,
   input  logic [SNN_VEC_W-1:0]                i_rd_data,
   output logic [SNN_VEC_W-1:0]                o_spike_vec,
   output logic                                o_learn_en,
   output logic [$clog2(P_EPOCHS_TRAIN):0]     o_epoch,
   output logic                                o_busy,
   output logic                                o_done
);

   localparam int AW       = snn_width(P_TEST_LEN);
   localparam int EW       = $clog2(P_EPOCHS_TRAIN) + 1;
   // A zero spike gap still gets one HOLD cycle.
   localparam int HOLD_LEN = snn_max(P_SPIKE_GAP, 1);
   localparam int CW       = snn_width(snn_max(P_PATTERN_GAP, HOLD_LEN));

   localparam logic [CW-1:0] GAP_LOAD   = CW'((P_PATTERN_GAP > 0) ? (P_PATTERN_GAP - 1) : 0);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_LEN - 1);
   localparam logic [AW-1:0] ADDR_LAST  = AW'(P_TEST_LEN - 1);
   localparam logic [EW-1:0] EPOCH_ONE  = EW'(1);
   localparam logic [EW-1:0] EPOCH_TRN  = EW'(P_EPOCHS_TRAIN);
   localparam logic [EW-1:0] EPOCH_TST  = EW'(P_EPOCHS_TEST);
   localparam logic [1:0]    FRAME_LAST = 2'(P_FRAMES - 1);
   localparam bit            GAP_SKIP   = (P_PATTERN_GAP == 0);

   snn_state_t     state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [1:0]     frame_q, frame_d;
   logic [EW-1:0]  epoch_q, epoch_d;
   logic [EW-1:0]  epoch_lim;
   logic           enter_gap;
   logic           cnt_load;
   logic [CW-1:0]  cnt_load_val;
   logic           cnt_pause;
   logic           cnt_expire;
   logic           timed_state;

   assign timed_state = (state_q == ST_GAP) || (state_q == ST_HOLD);
   // Pause only matters where a delay is being timed.
   assign cnt_pause   = i_pause && timed_state;
   assign epoch_lim   = (frame_q == 2'd0) ? EPOCH_TRN : EPOCH_TST;

   snn_delay_counter #(
      .P_W (CW)
   ) u_delay (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (cnt_load),
      .i_load_val (cnt_load_val),
      .i_pause    (cnt_pause),
      .o_expire   (cnt_expire)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         frame_q <= 2'd0;
         epoch_q <= EPOCH_ONE;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         frame_q <= frame_d;
         epoch_q <= epoch_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      frame_d      = frame_q;
      epoch_d      = epoch_q;
      enter_gap    = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               addr_d    = '0;
               frame_d   = 2'd0;
               epoch_d   = EPOCH_ONE;
               enter_gap = 1'b1;
            end
         end
         ST_GAP: begin
            if (!i_pause && cnt_expire) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            state_d      = ST_HOLD;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LOAD;
         end
         ST_HOLD: begin
            if (!i_pause && cnt_expire) begin
               if (addr_q != ADDR_LAST) begin
                  addr_d  = addr_q + AW'(1);
                  state_d = ST_FETCH;
               end else begin
                  addr_d = '0;
                  if (epoch_q < epoch_lim) begin
                     epoch_d   = epoch_q + EW'(1);
                     enter_gap = 1'b1;
                  end else if (frame_q < FRAME_LAST) begin
                     frame_d   = frame_q + 2'd1;
                     epoch_d   = EPOCH_ONE;
                     enter_gap = 1'b1;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A zero-length gap bypasses GAP entirely so no cycle is spent there.
      if (enter_gap) begin
         if (GAP_SKIP) begin
            state_d = ST_FETCH;
         end else begin
            state_d      = ST_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
         end
      end
   end

   assign o_rd_en     = (state_q == ST_FETCH);
   assign o_spike_vec = (state_q == ST_EMIT) ? i_rd_data : '0;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = (state_q == ST_DONE);
   assign o_learn_en  = (frame_q == 2'd0) && (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign o_addr      = addr_q;
   assign o_frame     = frame_q;
   assign o_epoch     = epoch_q;

endmodule

// File: doc/snn_phase_scheduler.md
SNN_PHASE_SCHEDULER -- requirements
Module: snn_phase_scheduler

Interface
REQ-001 Parameter P_TEST_LEN, default 9000; spike vectors per epoch.
REQ-002 Parameter P_PATTERN_GAP, default 100; idle cycles before each epoch.
REQ-003 Parameter P_SPIKE_GAP, default 3; zero-vector cycles after each emitted vector.
REQ-004 Parameter P_EPOCHS_TRAIN, default 100; epochs in frame 0.
REQ-005 Parameter P_EPOCHS_TEST, default 50; epochs in each frame 1..P_FRAMES-1.
REQ-006 Parameter P_FRAMES, default 4, range 1..4; number of pattern-set frames.
REQ-007 i_clk  in  1  clock; all state updates occur on its rising edge.
REQ-008 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-009 i_start  in  1  run request; accepted only in IDLE.
REQ-010 i_pause  in  1  freezes timing while in GAP or HOLD.
REQ-011 o_rd_en  out  1  pattern-memory read strobe.
REQ-012 o_addr  out  clog2(P_TEST_LEN)  read address.
REQ-013 o_frame  out  2  pattern-set select.
REQ-014 i_rd_data  in  42  memory data, valid one cycle after o_rd_en.
REQ-015 o_spike_vec  out  42  spike vector to the network.
REQ-016 o_learn_en  out  1  STDP enable.
REQ-017 o_epoch  out  clog2(P_EPOCHS_TRAIN)+1  current epoch, 1-based.
REQ-018 o_busy  out  1  high in every state except IDLE.
REQ-019 o_done  out  1  one-cycle pulse at end of the run.

Function
REQ-020 States: IDLE, GAP, FETCH, EMIT, HOLD, DONE.
REQ-021 IDLE: on i_start=1, go to GAP with epoch=1, frame=0, addr=0, delay counter=0.
REQ-022 GAP: stay P_PATTERN_GAP cycles, then go to FETCH; P_PATTERN_GAP=0 goes directly to FETCH.
REQ-023 FETCH: hold o_rd_en=1 for one cycle with the current o_addr, then go to EMIT.
REQ-024 EMIT: drive o_spike_vec=i_rd_data for exactly one cycle, then go to HOLD.
REQ-025 HOLD: drive o_spike_vec=0 for P_SPIKE_GAP cycles (minimum 1), then advance.
REQ-026 On HOLD exit:
  - addr<P_TEST_LEN-1: addr+1, go to FETCH.
  - Otherwise addr wraps to 0.
  - If more epochs remain in the frame: epoch+1, go to GAP.
  - Else if frame<P_FRAMES-1: frame+1, epoch=1, go to GAP.
  - Else: go to DONE.
REQ-027 Epoch limit: P_EPOCHS_TRAIN when frame=0, else P_EPOCHS_TEST.
REQ-028 o_learn_en=1 only while frame=0 and in GAP, FETCH, EMIT or HOLD.
REQ-029 DONE: assert o_done for one cycle, then go to IDLE; o_frame, o_epoch and o_addr keep their final values until the next start.
REQ-030 i_pause=1 in GAP or HOLD freezes the delay counter and the state; it is ignored in FETCH and EMIT.
REQ-031 i_start while o_busy=1 is ignored.
REQ-032 o_spike_vec=0 in every state except EMIT.
REQ-033 Cycle count of one epoch with no pause: P_PATTERN_GAP + P_TEST_LEN*(2+P_SPIKE_GAP).

Reset
REQ-034 Asserting i_rst_n=0 in any state forces IDLE immediately, asynchronously.
REQ-035 Reset values: o_rd_en=0, o_addr=0, o_frame=0, o_spike_vec=0, o_learn_en=0, o_epoch=1, o_busy=0, o_done=0, delay counter=0.
REQ-036 After reset release, no activity occurs until i_start is accepted.

Structure
REQ-037 Shared package snn_pkg holds the state enum and SNN_VEC_W=42.
REQ-038 The shared delay counter for GAP and HOLD is a sub-module, snn_delay_counter, with load, pause and expire.

Verification
(Bench parameters: P_TEST_LEN=4, P_PATTERN_GAP=2, P_SPIKE_GAP=1, P_EPOCHS_TRAIN=2, P_EPOCHS_TEST=1, P_FRAMES=2.)
REQ-039 Full run: i_start pulse, memory returns addr+1 -> vectors 1,2,3,4 emitted three times (learn_en=1 twice, frame=1 once); o_done pulses exactly 42 cycles after i_start is accepted.
REQ-040 Latency: o_rd_en at addr=2 -> o_spike_vec equals i_rd_data on the next cycle only, then 0.
REQ-041 Pause: i_pause=1 for 5 cycles during HOLD -> run lengthens by exactly 5 cycles; pause in EMIT has no effect.
REQ-042 Reset mid-run: i_rst_n low in EMIT of frame 1 -> all outputs take reset values in the same cycle, with no o_done.
REQ-043 Start while busy: i_start at cycle 10 -> no effect on the sequence or o_done timing.
REQ-044 Boundary: P_PATTERN_GAP=0, P_FRAMES=1 -> FETCH follows IDLE directly; DONE follows the last HOLD.
